// File: rtl/pipeline_decoder.sv
// Receive-side decoder: undoes enc = (((d + ADD_K) * 3) & 12'hFFF) ^ XOR_K over three
// valid/ready pipeline stages and flags words whose upper nibble could not come from the encoder.
`timescale 1ns/1ps
module pipeline_decoder #(
    parameter int          ADD_K     = 5,
    parameter logic [11:0] XOR_K     = 12'h0AA,
    parameter int          INV_MUL   = 2731,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [11:0]          out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [11:0] ADD_K_V   = 12'(ADD_K);
    localparam logic [11:0] INV_MUL_V = 12'(INV_MUL);

    logic        v1, v2, v3;
    logic        e1, e2, e3;
    logic [11:0] x1, x2, x3;
    logic        adv1, adv2, adv3;
    logic [11:0] x1_mul;

    // Handshake: a word moves across an interface on a clock edge where valid and ready are
    // both high; a stage advances when downstream takes its word or it is empty, so bubbles close up.
    assign adv3     = out_ready | ~v3;
    assign adv2     = adv3 | ~v2;
    assign adv1     = adv2 | ~v1;
    assign in_ready = adv1;

    // Constant multiply by the inverse of 3, unrolled into a sum of shifted copies of x1.
    always_comb begin
        x1_mul = '0;
        for (int i = 0; i < 12; i++) begin
            if (INV_MUL_V[i]) x1_mul = x1_mul + (x1 << i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            x1 <= '0;
            e1 <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
            x1 <= in_data[11:0] ^ XOR_K;
            e1 <= |in_data[15:12];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            x2 <= '0;
            e2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            x2 <= x1_mul;
            e2 <= e1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3 <= 1'b0;
            x3 <= '0;
            e3 <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            x3 <= x2 - ADD_K_V;
            e3 <= e2;
        end
    end

    assign out_data  = x3;
    assign out_err   = e3;
    assign out_valid = v3;

    // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_decoder.sv
// Bench for pipeline_decoder: vector table, scoreboard queue, back-pressure, error counter
// and mid-flight reset sequences.
`timescale 1ns/1ps
module tb_pipeline_decoder;

    localparam int ERR_CNT_W = 8;

    logic                 clk;
    logic                 rst_n;
    logic [15:0]          in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [11:0]          out_data;
    logic                 out_err;
    logic                 out_valid;
    logic                 out_ready;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_count;

    typedef struct {
        logic [15:0] din;
        logic [11:0] dout;
        logic        err;
    } vec_t;

    vec_t                 vecs[8];
    logic [12:0]          exp_q[$];
    logic [12:0]          cur_exp;
    logic [12:0]          got;
    logic [12:0]          held;
    logic                 hold_pending;
    logic [ERR_CNT_W-1:0] model_cnt;
    int                   n_checks;
    int                   n_fail;

    pipeline_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [15:0] encode(input logic [15:0] d);
        logic [15:0] t;
        t = ((d + 16'd5) * 16'd3) & 16'h0FFF;
        return t ^ 16'h00AA;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] din, input logic [12:0] e);
        bit ok;
        ok       = 1'b0;
        in_data  = din;
        cur_exp  = e;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) return;
            @(posedge clk);
            lat++;
        end
        lat = -1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        check("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_cnt    = '0;
            hold_pending = 1'b0;
        end else begin
            check("err_count", err_count, model_cnt);
            if (hold_pending) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_word", {out_err, out_data}, held);
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {out_err, out_data}, 13'h1FFF ^ {out_err, out_data});
                end else begin
                    got = exp_q.pop_front();
                    check("out_word", {out_err, out_data}, got);
                end
                if (out_err && model_cnt != '1) model_cnt = model_cnt + 1'b1;
            end
            if (err_clr) model_cnt = '0;
            hold_pending = out_valid && !out_ready;
            held         = {out_err, out_data};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int acc;
        int sent;
        logic [15:0] d;
        logic [15:0] din;
        logic        e;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        cur_exp   = '0;

        vecs[0] = '{16'h00A5, 12'h000, 1'b0};
        vecs[1] = '{16'h0601, 12'h234, 1'b0};
        vecs[2] = '{16'h00A6, 12'hFFF, 1'b0};
        vecs[3] = '{16'h03D2, 12'h123, 1'b0};
        vecs[4] = '{16'h00AA, 12'hFFB, 1'b0};
        vecs[5] = '{16'hF0A5, 12'h000, 1'b1};
        vecs[6] = '{16'h10AA, 12'hFFB, 1'b1};
        vecs[7] = '{16'hFFFF, 12'hFC2, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 12'h000);
        check("rst_out_err", out_err, 1'b0);
        check("rst_err_count", err_count, 8'h00);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_out_valid", out_valid, 1'b0);
        tick();

        // table-driven single words through an empty pipe
        out_ready = 1'b1;
        foreach (vecs[k]) begin
            send(vecs[k].din, {vecs[k].err, vecs[k].dout});
            in_valid = 1'b0;
            wait_out(lat);
            check("vec_latency", lat, 32'd3);
            check("vec_data", out_data, vecs[k].dout);
            check("vec_err", out_err, vecs[k].err);
            tick();
        end

        // back-to-back pair emerges on consecutive clocks
        send(16'h0601, {1'b0, 12'h234});
        send(16'h00A6, {1'b0, 12'hFFF});
        in_valid = 1'b0;
        wait_valid();
        check("b2b_first", out_data, 12'h234);
        @(negedge clk);
        check("b2b_second_valid", out_valid, 1'b1);
        check("b2b_second", out_data, 12'hFFF);
        tick();
        drain();

        // back-pressure: five offered, three accepted
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            d        = 16'(i * 7 + 1);
            in_data  = encode(d);
            cur_exp  = {1'b0, d[11:0]};
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, 32'd3);
        @(negedge clk);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_held_data", out_data, 12'h001);
        repeat (3) @(negedge clk);
        tick();
        drain();

        // random loopback through the encoder model
        sent = 0;
        for (int cyc = 0; cyc < 6000 && sent < 200; cyc++) begin
            d   = 16'($urandom);
            e   = ($urandom_range(0, 7) == 0);
            din = encode(d);
            if (e) din[15:12] = 4'($urandom_range(1, 15));
            in_data   = din;
            cur_exp   = {e, d[11:0]};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
        end
        check("rand_sent", sent, 32'd200);
        drain();

        // error counter saturation
        out_ready = 1'b1;
        for (int i = 0; i < (1 << ERR_CNT_W) + 3; i++) send(16'hF0A5, {1'b1, 12'h000});
        drain();
        @(negedge clk);
        check("err_saturated", err_count, 8'hFF);
        tick();

        // clear on the same clock as an error handshake
        out_ready = 1'b0;
        send(16'h10AA, {1'b1, 12'hFFB});
        in_valid = 1'b0;
        wait_valid();
        tick();
        err_clr   = 1'b1;
        out_ready = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("clr_wins", err_count, 8'h00);
        tick();

        // reset with three words in flight
        out_ready = 1'b0;
        send(encode(16'h0111), {1'b0, 12'h111});
        send(encode(16'h0222), {1'b0, 12'h222});
        send(encode(16'h0333), {1'b0, 12'h333});
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        @(negedge clk);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 1'b0);
        end
        tick();
        send(encode(16'h0456), {1'b0, 12'h456});
        in_valid = 1'b0;
        wait_out(lat);
        check("post_rst_latency", lat, 32'd3);
        check("post_rst_data", out_data, 12'h456);
        tick();
        drain();

        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
